trisc_ldstm_seq: RTL and testbench

- Multi-register load/store sequencer for the T-RISC core family; replaces the single-register push/pop path (highest set bit only) with full ARM-style register-list transfers.
- Covers POP/LDMIA (increment-after) and PUSH/STMDB (decrement-before), with optional base writeback.
- Parametrised in data width, register count and memory read latency.
- Sits between the decoder/register file and the data RAM port; stalls the core via busy.

---
 rtl/trisc_ldstm_seq.sv | 181 ++++++++++++++++++
 tb/tb_trisc_ldstm_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trisc_ldstm_seq.sv
// Multi-register load/store sequencer (LDMIA/POP, STMDB/PUSH) with optional base writeback.
// Optional alignment-error reporting is enabled by defining TRISC_LDSTM_ALIGN_ERR_EN.
module trisc_ldstm_seq #(
    parameter int WD      = 32,
    parameter int NR      = 16,
    parameter int SP_IDX  = 13,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_load,
    input  logic                  wb,
    input  logic [$clog2(NR)-1:0] base_idx,
    input  logic [WD-1:0]         base,
    input  logic [NR-1:0]         reglist,
    output logic [$clog2(NR)-1:0] rf_raddr,
    input  logic [WD-1:0]         rf_rdata,
    output logic                  rf_we,
    output logic [$clog2(NR)-1:0] rf_waddr,
    output logic [WD-1:0]         rf_wdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [WD-1:0]         mem_addr,
    output logic [WD-1:0]         mem_wdata,
    input  logic [WD-1:0]         mem_rdata,
    output logic                  pc_load,
    output logic [WD-1:0]         pc_value,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int AW = $clog2(NR);
    localparam int CW = $clog2(NR + 1);
    localparam logic [AW-1:0] PC_IDX = AW'(NR - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WB} state_t;

    state_t               state, state_nx;
    logic [NR-1:0]        rem_q, rem_nx;
    logic                 is_load_q, wb_en_q;
    logic [AW-1:0]        base_idx_q, cur_idx;
    logic [WD-1:0]        addr_q, wb_val_q;
    logic [CW-1:0]        n_cnt;
    logic [WD-1:0]        base_al, n_bytes;
    logic                 last, misal, issue_vld, inflight;
    logic [MEM_LAT:1]         vld_pipe;
    logic [MEM_LAT:1][AW-1:0] tag_pipe;

    // The stack-pointer index is informational only for this block.
    logic unused_sp;
    assign unused_sp = (SP_IDX < NR);

    always_comb begin
        n_cnt = '0;
        for (int i = 0; i < NR; i++) n_cnt = n_cnt + CW'(reglist[i]);
    end

    assign base_al = base & ~WD'(3);
    assign n_bytes = WD'(n_cnt) << 2;

`ifdef TRISC_LDSTM_ALIGN_ERR_EN
    logic err_q;
    assign misal = |base[1:0];
    assign err   = (state == WB) && err_q;
`else
    assign misal = 1'b0;
    assign err   = 1'b0;
`endif

    // Lowest remaining register goes next so it lands at the lowest address.
    always_comb begin
        cur_idx = '0;
        for (int i = NR - 1; i >= 0; i--)
            if (rem_q[i]) cur_idx = AW'(i);
    end

    assign rem_nx    = rem_q & (rem_q - NR'(1));
    assign last      = (rem_nx == '0);
    assign issue_vld = (state == ISSUE) && is_load_q;

    // Anything still in flight after this cycle's return keeps DRAIN alive.
    always_comb begin
        inflight = 1'b0;
        for (int s = 1; s < MEM_LAT; s++) inflight = inflight | vld_pipe[s];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rem_q      <= '0;
            is_load_q  <= 1'b0;
            wb_en_q    <= 1'b0;
            base_idx_q <= '0;
            addr_q     <= '0;
            wb_val_q   <= '0;
            vld_pipe   <= '0;
            tag_pipe   <= '0;
`ifdef TRISC_LDSTM_ALIGN_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            vld_pipe[1] <= issue_vld;
            tag_pipe[1] <= cur_idx;
            for (int s = 2; s <= MEM_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
            if (state == IDLE && start) begin
                rem_q      <= reglist;
                is_load_q  <= is_load;
                base_idx_q <= base_idx;
                addr_q     <= is_load ? base_al : base_al - n_bytes;
                wb_val_q   <= is_load ? base_al + n_bytes : base_al - n_bytes;
                // A loaded base register takes precedence over the writeback.
                wb_en_q    <= wb && (n_cnt != '0) && !(is_load && reglist[base_idx]) && !misal;
`ifdef TRISC_LDSTM_ALIGN_ERR_EN
                err_q      <= misal;
`endif
            end else if (state == ISSUE) begin
                rem_q  <= rem_nx;
                addr_q <= addr_q + WD'(4);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = (misal || n_cnt == '0) ? WB : ISSUE;
            ISSUE: if (last)  state_nx = is_load_q ? DRAIN : WB;
            DRAIN: if (!inflight) state_nx = WB;
            WB:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rf_raddr  = '0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        pc_load   = 1'b0;
        pc_value  = '0;
        busy      = (state != IDLE);
        done      = 1'b0;
        if (state == ISSUE) begin
            mem_en   = 1'b1;
            mem_addr = addr_q;
            if (!is_load_q) begin
                mem_we    = 1'b1;
                rf_raddr  = cur_idx;
                mem_wdata = rf_rdata;
            end
        end
        if (vld_pipe[MEM_LAT]) begin
            rf_we    = 1'b1;
            rf_waddr = tag_pipe[MEM_LAT];
            rf_wdata = mem_rdata;
            if (tag_pipe[MEM_LAT] == PC_IDX) begin
                pc_load  = 1'b1;
                pc_value = mem_rdata;
            end
        end
        if (state == WB) begin
            done = 1'b1;
            if (wb_en_q) begin
                rf_we    = 1'b1;
                rf_waddr = base_idx_q;
                rf_wdata = wb_val_q;
            end
        end
    end

endmodule

// File: tb/tb_trisc_ldstm_seq.sv
// Directed bench for trisc_ldstm_seq (MEM_LAT=2) with register-file and memory models.
module tb_trisc_ldstm_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, is_load = 1'b0, wb = 1'b0;
    logic [3:0]  base_idx = '0;
    logic [31:0] base = '0;
    logic [15:0] reglist = '0;
    logic [3:0]  rf_raddr, rf_waddr;
    logic [31:0] rf_rdata, rf_wdata, mem_addr, mem_wdata, mem_rdata, pc_value;
    logic        rf_we, mem_en, mem_we, pc_load, busy, done, err;

    int total = 0;
    int bad   = 0;

    trisc_ldstm_seq #(.WD(32), .NR(16), .SP_IDX(13), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .wb(wb),
        .base_idx(base_idx), .base(base), .reglist(reglist),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pc_load(pc_load),
        .pc_value(pc_value), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Register file: ri = 0xA0 + i out of reset, written by the DUT.
    logic [31:0] rf [0:15];
    assign rf_rdata = rf[rf_raddr];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'hA0 + i;
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // Memory with two-cycle read latency.
    logic [31:0] mem [0:255];
    logic [31:0] rd1, rd2;
    assign mem_rdata = rd2;
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        rd1 <= mem[mem_addr[9:2]];
        rd2 <= rd1;
    end

    typedef struct {
        logic busy, done, err, mem_en, mem_we, rf_we, pc_load;
        logic [31:0] mem_addr, mem_wdata, rf_wdata, pc_value;
        logic [3:0]  rf_waddr;
    } snap_t;
    snap_t snap [0:15];

    task automatic kick(input logic l, input logic w, input logic [3:0] bi,
                        input logic [31:0] b, input logic [15:0] rl);
        @(negedge clk);
        is_load = l; wb = w; base_idx = bi; base = b; reglist = rl; start = 1'b1;
    endtask

    task automatic run(input int ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            snap[c].busy = busy;       snap[c].done = done;         snap[c].err = err;
            snap[c].mem_en = mem_en;   snap[c].mem_we = mem_we;     snap[c].rf_we = rf_we;
            snap[c].pc_load = pc_load; snap[c].mem_addr = mem_addr; snap[c].mem_wdata = mem_wdata;
            snap[c].rf_wdata = rf_wdata; snap[c].pc_value = pc_value; snap[c].rf_waddr = rf_waddr;
            if (c == 1) start = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, err, mem_en, mem_we, rf_we, pc_load} !== 7'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rf_wdata !== 32'h0 || pc_value !== 32'h0) begin
            bad++;
            $display("FAIL reset: got busy=%b done=%b en=%b we=%b rfwe=%b addr=%h want all zero",
                     busy, done, mem_en, mem_we, rf_we, mem_addr);
        end
        reset = 1'b1;
    endtask

    task automatic test_push;
        logic [31:0] ea [1:3];
        logic [31:0] ed [1:3];
        ea[1] = 32'hF4; ea[2] = 32'hF8; ea[3] = 32'hFC;
        ed[1] = 32'hA0; ed[2] = 32'hA1; ed[3] = 32'hAE;
        kick(1'b0, 1'b1, 4'd13, 32'h100, 16'h4003);
        run(5);
        for (int c = 1; c <= 3; c++) begin
            total++;
            if (snap[c].mem_en !== 1'b1 || snap[c].mem_we !== 1'b1 || snap[c].mem_addr !== ea[c] ||
                snap[c].mem_wdata !== ed[c] || snap[c].rf_we !== 1'b0 || snap[c].done !== 1'b0) begin
                bad++;
                $display("FAIL push_c%0d: got en=%b we=%b addr=%h data=%h want addr=%h data=%h",
                         c, snap[c].mem_en, snap[c].mem_we, snap[c].mem_addr, snap[c].mem_wdata, ea[c], ed[c]);
            end
        end
        total++;
        if (snap[4].done !== 1'b1 || snap[4].rf_we !== 1'b1 || snap[4].rf_waddr !== 4'd13 ||
            snap[4].rf_wdata !== 32'hF4 || snap[4].mem_en !== 1'b0) begin
            bad++;
            $display("FAIL push_wb: got done=%b we=%b waddr=%0d wdata=%h want done=1 we=1 waddr=13 wdata=f4",
                     snap[4].done, snap[4].rf_we, snap[4].rf_waddr, snap[4].rf_wdata);
        end
        for (int c = 1; c <= 5; c++) begin
            total++;
            if (snap[c].busy !== (c <= 4)) begin
                bad++;
                $display("FAIL push_busy_c%0d: got %b want %b", c, snap[c].busy, (c <= 4));
            end
        end
    endtask

    task automatic test_pop_pc;
        kick(1'b1, 1'b1, 4'd13, 32'hF4, 16'h8010);
        run(6);
        total++;
        if (snap[1].mem_en !== 1'b1 || snap[1].mem_we !== 1'b0 || snap[1].mem_addr !== 32'hF4 ||
            snap[2].mem_en !== 1'b1 || snap[2].mem_we !== 1'b0 || snap[2].mem_addr !== 32'hF8) begin
            bad++;
            $display("FAIL pop_reads: got a1=%h a2=%h we1=%b we2=%b want f4 f8 0 0",
                     snap[1].mem_addr, snap[2].mem_addr, snap[1].mem_we, snap[2].mem_we);
        end
        total++;
        if (snap[3].rf_we !== 1'b1 || snap[3].rf_waddr !== 4'd4 || snap[3].rf_wdata !== 32'hA0 ||
            snap[3].pc_load !== 1'b0 || snap[3].mem_en !== 1'b0) begin
            bad++;
            $display("FAIL pop_r4: got we=%b waddr=%0d wdata=%h pc=%b want 1 4 a0 0",
                     snap[3].rf_we, snap[3].rf_waddr, snap[3].rf_wdata, snap[3].pc_load);
        end
        total++;
        if (snap[4].pc_load !== 1'b1 || snap[4].pc_value !== 32'hA1 || snap[4].rf_we !== 1'b1 ||
            snap[4].rf_waddr !== 4'd15 || snap[4].done !== 1'b0) begin
            bad++;
            $display("FAIL pop_pc: got pc_load=%b pc=%h we=%b waddr=%0d done=%b want 1 a1 1 15 0",
                     snap[4].pc_load, snap[4].pc_value, snap[4].rf_we, snap[4].rf_waddr, snap[4].done);
        end
        total++;
        if (snap[5].done !== 1'b1 || snap[5].rf_we !== 1'b1 || snap[5].rf_waddr !== 4'd13 ||
            snap[5].rf_wdata !== 32'hFC || snap[5].pc_load !== 1'b0 || snap[6].busy !== 1'b0) begin
            bad++;
            $display("FAIL pop_wb: got done=%b we=%b waddr=%0d wdata=%h busy6=%b want 1 1 13 fc 0",
                     snap[5].done, snap[5].rf_we, snap[5].rf_waddr, snap[5].rf_wdata, snap[6].busy);
        end
    endtask

    task automatic test_base_in_list;
        kick(1'b1, 1'b1, 4'd13, 32'hF4, 16'h2001);
        run(6);
        total++;
        if (snap[4].rf_we !== 1'b1 || snap[4].rf_waddr !== 4'd13 || snap[4].rf_wdata !== 32'hA1 ||
            snap[4].pc_load !== 1'b0) begin
            bad++;
            $display("FAIL bil_load: got we=%b waddr=%0d wdata=%h pc=%b want 1 13 a1 0",
                     snap[4].rf_we, snap[4].rf_waddr, snap[4].rf_wdata, snap[4].pc_load);
        end
        total++;
        if (snap[5].done !== 1'b1 || snap[5].rf_we !== 1'b0) begin
            bad++;
            $display("FAIL bil_nowb: got done=%b rf_we=%b want done=1 rf_we=0", snap[5].done, snap[5].rf_we);
        end
        total++;
        if (rf[13] !== 32'hA1) begin
            bad++;
            $display("FAIL bil_r13: got %h want a1", rf[13]);
        end
    endtask

    task automatic test_empty;
        kick(1'b1, 1'b1, 4'd13, 32'h200, 16'h0000);
        run(3);
        total++;
        if (snap[1].done !== 1'b1 || snap[1].busy !== 1'b1 || snap[1].rf_we !== 1'b0 ||
            snap[2].busy !== 1'b0 || snap[2].done !== 1'b0) begin
            bad++;
            $display("FAIL empty_done: got done1=%b busy1=%b we1=%b busy2=%b want 1 1 0 0",
                     snap[1].done, snap[1].busy, snap[1].rf_we, snap[2].busy);
        end
        total++;
        if (snap[1].mem_en !== 1'b0 || snap[2].mem_en !== 1'b0 || snap[3].mem_en !== 1'b0 ||
            snap[2].rf_we !== 1'b0 || snap[3].rf_we !== 1'b0) begin
            bad++;
            $display("FAIL empty_quiet: got en=%b%b%b we=%b%b want 000 00",
                     snap[1].mem_en, snap[2].mem_en, snap[3].mem_en, snap[2].rf_we, snap[3].rf_we);
        end
    endtask

    task automatic test_start_ignored;
        kick(1'b0, 1'b0, 4'd13, 32'h300, 16'h0006);
        @(negedge clk);
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2F8 || mem_wdata !== 32'hA1) begin
            bad++;
            $display("FAIL ign_c1: got en=%b we=%b addr=%h data=%h want 1 1 2f8 a1", mem_en, mem_we, mem_addr, mem_wdata);
        end
        is_load = 1'b1; reglist = 16'hFFFF; base = 32'h500;
        @(negedge clk);
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2FC || mem_wdata !== 32'hA2) begin
            bad++;
            $display("FAIL ign_c2: got en=%b we=%b addr=%h data=%h want 1 1 2fc a2", mem_en, mem_we, mem_addr, mem_wdata);
        end
        start = 1'b0;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || rf_we !== 1'b0 || mem_en !== 1'b0) begin
            bad++;
            $display("FAIL ign_done: got done=%b rf_we=%b en=%b want 1 0 0", done, rf_we, mem_en);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            bad++;
            $display("FAIL ign_idle: got busy=%b en=%b want 0 0", busy, mem_en);
        end
    endtask

    task automatic test_reset_mid;
        kick(1'b0, 1'b1, 4'd13, 32'h400, 16'h00FF);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 32'h3E4) begin
            bad++;
            $display("FAIL rst_pre: got busy=%b en=%b addr=%h want 1 1 3e4", busy, mem_en, mem_addr);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({busy, done, err, mem_en, mem_we, rf_we, pc_load} !== 7'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rf_wdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid: got busy=%b en=%b we=%b addr=%h data=%h want all zero",
                     busy, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            bad++;
            $display("FAIL rst_after: got busy=%b en=%b want 0 0", busy, mem_en);
        end
    endtask

    task automatic test_push_after_reset;
        kick(1'b0, 1'b1, 4'd13, 32'h200, 16'h0003);
        run(4);
        total++;
        if (snap[1].mem_addr !== 32'h1F8 || snap[1].mem_wdata !== 32'hA0 || snap[1].mem_we !== 1'b1 ||
            snap[2].mem_addr !== 32'h1FC || snap[2].mem_wdata !== 32'hA1 || snap[2].mem_we !== 1'b1) begin
            bad++;
            $display("FAIL par_xfer: got a1=%h d1=%h a2=%h d2=%h want 1f8 a0 1fc a1",
                     snap[1].mem_addr, snap[1].mem_wdata, snap[2].mem_addr, snap[2].mem_wdata);
        end
        total++;
        if (snap[3].done !== 1'b1 || snap[3].rf_we !== 1'b1 || snap[3].rf_waddr !== 4'd13 ||
            snap[3].rf_wdata !== 32'h1F8 || snap[4].busy !== 1'b0) begin
            bad++;
            $display("FAIL par_wb: got done=%b we=%b waddr=%0d wdata=%h busy4=%b want 1 1 13 1f8 0",
                     snap[3].done, snap[3].rf_we, snap[3].rf_waddr, snap[3].rf_wdata, snap[4].busy);
        end
    endtask

    task automatic test_align;
        kick(1'b0, 1'b1, 4'd13, 32'h102, 16'h0001);
        run(3);
`ifdef TRISC_LDSTM_ALIGN_ERR_EN
        total++;
        if (snap[1].err !== 1'b1 || snap[1].done !== 1'b1 || snap[1].busy !== 1'b1 ||
            snap[1].mem_en !== 1'b0 || snap[1].rf_we !== 1'b0) begin
            bad++;
            $display("FAIL align_err: got err=%b done=%b busy=%b en=%b we=%b want 1 1 1 0 0",
                     snap[1].err, snap[1].done, snap[1].busy, snap[1].mem_en, snap[1].rf_we);
        end
        total++;
        if (snap[2].busy !== 1'b0 || snap[2].err !== 1'b0 || snap[2].mem_en !== 1'b0 || snap[2].rf_we !== 1'b0) begin
            bad++;
            $display("FAIL align_idle: got busy=%b err=%b en=%b we=%b want 0 0 0 0",
                     snap[2].busy, snap[2].err, snap[2].mem_en, snap[2].rf_we);
        end
`else
        total++;
        if (snap[1].mem_en !== 1'b1 || snap[1].mem_addr !== 32'hFC || snap[1].mem_wdata !== 32'hA0 ||
            snap[1].err !== 1'b0) begin
            bad++;
            $display("FAIL align_xfer: got en=%b addr=%h data=%h err=%b want 1 fc a0 0",
                     snap[1].mem_en, snap[1].mem_addr, snap[1].mem_wdata, snap[1].err);
        end
        total++;
        if (snap[2].done !== 1'b1 || snap[2].err !== 1'b0 || snap[2].rf_we !== 1'b1 ||
            snap[2].rf_wdata !== 32'hFC || snap[3].busy !== 1'b0) begin
            bad++;
            $display("FAIL align_wb: got done=%b err=%b we=%b wdata=%h busy3=%b want 1 0 1 fc 0",
                     snap[2].done, snap[2].err, snap[2].rf_we, snap[2].rf_wdata, snap[3].busy);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_push;
        test_pop_pc;
        test_base_in_list;
        test_empty;
        test_start_ignored;
        test_reset_mid;
        test_push_after_reset;
        test_align;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
